// File: rtl/lockstep_arb_pkg.sv
// rtl/lockstep_arb_pkg.sv - shared types and sizing helpers for the lockstep peripheral arbiter
// Purpose: FSM state encoding, default sizing constants and width helpers.
// Ports: none (package).
package lockstep_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  localparam int DEF_NB_REQ     = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;
  localparam int IDX_WIDTH      = $clog2(DEF_NB_REQ);

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_width(input int nb_req);
    return $clog2(nb_req);
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// rtl/rr_prio_select.sv - round-robin priority selector (rotate, priority-encode, unrotate)
// Purpose: pick the first set request bit starting at rr_ptr, wrapping modulo NB_REQ.
// Ports:
//   req    in  NB_REQ     request vector
//   rr_ptr in  IDX_WIDTH  highest-priority index for this round
//   valid  out 1          at least one request is set
//   winner out IDX_WIDTH  index of the selected request
module rr_prio_select #(
  parameter int NB_REQ    = 4,
  parameter int IDX_WIDTH = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0]    req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] winner
);

  // Walking offsets 0..NB_REQ-1 from rr_ptr is the rotate/encode/unrotate
  // sequence folded into one loop; the first hit wins.
  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NB_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDX_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/lockstep_periph_arbiter.sv
// rtl/lockstep_periph_arbiter.sv - round-robin arbiter in front of the lockstep unit peripheral slave port
// Purpose: grant one requester, buffer its request, forward it to the lockstep unit
//          and route the single outstanding response back to that requester.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_i/add_i/wen_i/wdata_i/be_i/id_i per-requester request and payload
//   gnt_o, r_valid_o                    one-hot grant / response valid per requester
//   r_opc_o/r_id_o/r_rdata_o            shared response fields, 0 when no r_valid_o
//   req_o/add_o/wen_o/wdata_o/be_o/id_o latched request towards the lockstep unit
//   gnt_i, r_valid_i/r_opc_i/r_id_i/r_rdata_i  grant and response from the lockstep unit
module lockstep_periph_arbiter
  import lockstep_arb_pkg::*;
#(
  parameter int NB_REQ     = DEF_NB_REQ,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = 5,
  localparam int BE_W      = be_width(DATA_WIDTH),
  localparam int IDX_W     = idx_width(NB_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NB_REQ-1:0]                  req_i,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]  add_i,
  input  logic [NB_REQ-1:0]                  wen_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NB_REQ-1:0][BE_W-1:0]        be_i,
  input  logic [NB_REQ-1:0][ID_WIDTH-1:0]    id_i,
  output logic [NB_REQ-1:0]                  gnt_o,
  output logic [NB_REQ-1:0]                  r_valid_o,
  output logic                               r_opc_o,
  output logic [ID_WIDTH-1:0]                r_id_o,
  output logic [DATA_WIDTH-1:0]              r_rdata_o,
  output logic                               req_o,
  output logic [ADDR_WIDTH-1:0]              add_o,
  output logic                               wen_o,
  output logic [DATA_WIDTH-1:0]              wdata_o,
  output logic [BE_W-1:0]                    be_o,
  output logic [ID_WIDTH-1:0]                id_o,
  input  logic                               gnt_i,
  input  logic                               r_valid_i,
  input  logic                               r_opc_i,
  input  logic [ID_WIDTH-1:0]                r_id_i,
  input  logic [DATA_WIDTH-1:0]              r_rdata_i
);

  arb_state_e            state_q, state_n;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      win_idx_q;
  logic                  sel_valid;
  logic [IDX_W-1:0]      sel_idx;
  logic                  accept;
  logic                  rsp_fire;

  // Response routing uses the latched id, so the returned id is not needed.
  logic unused_r_id;
  assign unused_r_id = ^r_id_i;

  rr_prio_select #(
    .NB_REQ    (NB_REQ),
    .IDX_WIDTH (IDX_W)
  ) u_sel (
    .req    (req_i),
    .rr_ptr (rr_ptr_q),
    .valid  (sel_valid),
    .winner (sel_idx)
  );

  assign accept   = (state_q == ST_IDLE) && sel_valid;
  assign rsp_fire = (state_q == ST_RSP) && r_valid_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_n;
  end

  // Next-state logic; r_valid_i outside RSP is ignored.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (sel_valid) state_n = ST_REQ;
      ST_REQ:  if (gnt_i)     state_n = ST_RSP;
      ST_RSP:  if (r_valid_i) state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  // Output logic. gnt_o is combinational from req_i, so it is also
  // masked by rst_ni to keep every output low while reset is asserted.
  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    r_opc_o   = 1'b0;
    r_id_o    = '0;
    r_rdata_o = '0;
    req_o     = 1'b0;
    case (state_q)
      ST_IDLE: if (sel_valid && rst_ni) gnt_o[sel_idx] = 1'b1;
      ST_REQ:  req_o = 1'b1;
      ST_RSP: begin
        if (r_valid_i) begin
          r_valid_o[win_idx_q] = 1'b1;
          r_opc_o              = r_opc_i;
          r_id_o               = id_o;
          r_rdata_o            = r_rdata_i;
        end
      end
      default: ;
    endcase
  end

  // Payload is captured only on acceptance, so requester changes during
  // REQ/RSP never reach the lockstep unit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      add_o     <= '0;
      wen_o     <= 1'b0;
      wdata_o   <= '0;
      be_o      <= '0;
      id_o      <= '0;
      win_idx_q <= '0;
    end else if (accept) begin
      add_o     <= add_i[sel_idx];
      wen_o     <= wen_i[sel_idx];
      wdata_o   <= wdata_i[sel_idx];
      be_o      <= be_i[sel_idx];
      id_o      <= id_i[sel_idx];
      win_idx_q <= sel_idx;
    end
  end

  // Priority moves just past the served requester once its response returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (rsp_fire) begin
      if (win_idx_q == IDX_W'(NB_REQ - 1)) rr_ptr_q <= '0;
      else                                 rr_ptr_q <= win_idx_q + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_lockstep_periph_arbiter.sv
// tb/tb_lockstep_periph_arbiter.sv - directed self-checking bench for lockstep_periph_arbiter
module tb_lockstep_periph_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [3:0]        req_i;
  logic [3:0][31:0]  add_i;
  logic [3:0]        wen_i;
  logic [3:0][31:0]  wdata_i;
  logic [3:0][3:0]   be_i;
  logic [3:0][4:0]   id_i;
  logic [3:0]        gnt_o;
  logic [3:0]        r_valid_o;
  logic              r_opc_o;
  logic [4:0]        r_id_o;
  logic [31:0]       r_rdata_o;
  logic              req_o;
  logic [31:0]       add_o;
  logic              wen_o;
  logic [31:0]       wdata_o;
  logic [3:0]        be_o;
  logic [4:0]        id_o;
  logic              gnt_i;
  logic              r_valid_i;
  logic              r_opc_i;
  logic [4:0]        r_id_i;
  logic [31:0]       r_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  lockstep_periph_arbiter dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .add_i     (add_i),
    .wen_i     (wen_i),
    .wdata_i   (wdata_i),
    .be_i      (be_i),
    .id_i      (id_i),
    .gnt_o     (gnt_o),
    .r_valid_o (r_valid_o),
    .r_opc_o   (r_opc_o),
    .r_id_o    (r_id_o),
    .r_rdata_o (r_rdata_o),
    .req_o     (req_o),
    .add_o     (add_o),
    .wen_o     (wen_o),
    .wdata_o   (wdata_o),
    .be_o      (be_o),
    .id_o      (id_o),
    .gnt_i     (gnt_i),
    .r_valid_i (r_valid_i),
    .r_opc_i   (r_opc_i),
    .r_id_i    (r_id_i),
    .r_rdata_i (r_rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_i     = 4'b1111;
    add_i     = '0;
    wen_i     = '0;
    wdata_i   = '0;
    be_i      = '0;
    id_i      = '0;
    gnt_i     = 1'b0;
    r_valid_i = 1'b0;
    r_opc_i   = 1'b0;
    r_id_i    = '0;
    r_rdata_i = '0;
    #2;
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_req", 64'(req_o), 64'h0);
    chk("rst_add", 64'(add_o), 64'h0);
    chk("rst_rvalid", 64'(r_valid_o), 64'h0);
    req_i = 4'b0000;
    cyc();
    cyc();
    rst_ni = 1'b1;

    // Single read from requester 1
    cyc();
    req_i    = 4'b0010;
    add_i[1] = 32'h1020_0004;
    wen_i[1] = 1'b1;
    id_i[1]  = 5'd3;
    gnt_i    = 1'b1;
    #1;
    chk("rd_gnt", 64'(gnt_o), 64'h2);
    chk("rd_req_idle", 64'(req_o), 64'h0);
    cyc();
    req_i = 4'b0000;
    #1;
    chk("rd_req", 64'(req_o), 64'h1);
    chk("rd_add", 64'(add_o), 64'h1020_0004);
    chk("rd_wen", 64'(wen_o), 64'h1);
    chk("rd_id", 64'(id_o), 64'h3);
    chk("rd_gnt_req", 64'(gnt_o), 64'h0);
    cyc();
    r_valid_i = 1'b1;
    r_rdata_i = 32'hDEAD_BEEF;
    r_id_i    = 5'd7;
    #1;
    chk("rd_rvalid", 64'(r_valid_o), 64'h2);
    chk("rd_rdata", 64'(r_rdata_o), 64'hDEAD_BEEF);
    chk("rd_rid", 64'(r_id_o), 64'h3);
    cyc();
    r_valid_i = 1'b0;
    #1;
    chk("rd_rvalid_off", 64'(r_valid_o), 64'h0);
    chk("rd_rdata_off", 64'(r_rdata_o), 64'h0);
    chk("rd_rid_off", 64'(r_id_o), 64'h0);

    // Round robin: all four requesting, starting from a fresh reset
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      id_i[k]  = 5'(k + 8);
      add_i[k] = 32'h4000_0000 + 32'(k * 4);
      wen_i[k] = 1'b1;
    end
    for (int t = 0; t < 8; t++) begin
      cyc();
      r_valid_i = 1'b0;
      req_i     = 4'b1111;
      #1;
      chk("rr_gnt", 64'(gnt_o), 64'(4'b0001 << (t % 4)));
      cyc();
      #1;
      chk("rr_add", 64'(add_o), 64'h4000_0000 + 64'((t % 4) * 4));
      cyc();
      r_valid_i = 1'b1;
      r_rdata_i = 32'hA0 + 32'(t);
      #1;
      chk("rr_rvalid", 64'(r_valid_o), 64'(4'b0001 << (t % 4)));
      chk("rr_rid", 64'(r_id_o), 64'((t % 4) + 8));
    end

    // Stall in REQ while requester 2 keeps changing its address
    cyc();
    r_valid_i = 1'b0;
    req_i     = 4'b0100;
    add_i[2]  = 32'h2000_0010;
    gnt_i     = 1'b0;
    #1;
    chk("st_gnt", 64'(gnt_o), 64'h4);
    for (int s = 0; s < 5; s++) begin
      cyc();
      add_i[2]  = 32'h3000_0000 + 32'(s);
      r_valid_i = (s == 2);
      #1;
      chk("st_req", 64'(req_o), 64'h1);
      chk("st_add", 64'(add_o), 64'h2000_0010);
      chk("st_rvalid_err", 64'(r_valid_o), 64'h0);
    end
    cyc();
    r_valid_i = 1'b0;
    gnt_i     = 1'b1;
    #1;
    chk("st_req_last", 64'(req_o), 64'h1);
    chk("st_add_last", 64'(add_o), 64'h2000_0010);
    cyc();
    r_valid_i = 1'b1;
    #1;
    chk("st_rvalid", 64'(r_valid_o), 64'h4);

    // Write with error from requester 0; rr_ptr=3 wraps to winner 0
    cyc();
    r_valid_i  = 1'b0;
    req_i      = 4'b0001;
    wen_i[0]   = 1'b0;
    be_i[0]    = 4'b0011;
    wdata_i[0] = 32'h55AA_1234;
    id_i[0]    = 5'h11;
    #1;
    chk("wr_gnt_wrap", 64'(gnt_o), 64'h1);
    cyc();
    req_i     = 4'b0000;
    r_valid_i = 1'b1;
    #1;
    chk("wr_wen", 64'(wen_o), 64'h0);
    chk("wr_be", 64'(be_o), 64'h3);
    chk("wr_wdata", 64'(wdata_o), 64'h55AA_1234);
    chk("wr_gnt_and_rvalid", 64'(r_valid_o), 64'h0);
    cyc();
    r_valid_i = 1'b0;
    r_opc_i   = 1'b1;
    #1;
    chk("wr_wait_rvalid", 64'(r_valid_o), 64'h0);
    chk("wr_wait_opc", 64'(r_opc_o), 64'h0);
    cyc();
    r_valid_i = 1'b1;
    #1;
    chk("wr_rvalid", 64'(r_valid_o), 64'h1);
    chk("wr_opc", 64'(r_opc_o), 64'h1);
    chk("wr_rid", 64'(r_id_o), 64'h11);

    // rr_ptr is now 1; requester 2 wins, then reset aborts it in RSP
    cyc();
    r_valid_i = 1'b0;
    req_i     = 4'b0100;
    #1;
    chk("wr_opc_off", 64'(r_opc_o), 64'h0);
    chk("ab_gnt", 64'(gnt_o), 64'h4);
    cyc();
    req_i = 4'b0000;
    #1;
    chk("ab_req", 64'(req_o), 64'h1);
    cyc();
    rst_ni    = 1'b0;
    r_valid_i = 1'b1;
    req_i     = 4'b1001;
    #1;
    chk("ab_rvalid", 64'(r_valid_o), 64'h0);
    chk("ab_req_rst", 64'(req_o), 64'h0);
    chk("ab_add_rst", 64'(add_o), 64'h0);
    chk("ab_id_rst", 64'(id_o), 64'h0);
    chk("ab_gnt_rst", 64'(gnt_o), 64'h0);
    chk("ab_rdata_rst", 64'(r_rdata_o), 64'h0);
    cyc();
    chk("ab_rvalid2", 64'(r_valid_o), 64'h0);
    rst_ni    = 1'b1;
    r_valid_i = 1'b0;
    #1;
    chk("ab_gnt_ptr0", 64'(gnt_o), 64'h1);
    cyc();
    req_i = 4'b0000;
    #1;
    chk("ab_req2", 64'(req_o), 64'h1);
    cyc();
    r_valid_i = 1'b1;
    #1;
    chk("ab_rvalid3", 64'(r_valid_o), 64'h1);

    // rr_ptr is now 1: requester 3 beats requester 0
    cyc();
    r_valid_i = 1'b0;
    req_i     = 4'b1001;
    #1;
    chk("rr_ptr1_gnt", 64'(gnt_o), 64'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
